// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
//   master (MEM stage): drives mem_addr, mem_wr_data, mem_rd, mem_wr;
//                       samples mem_done, mem_rd_data.
//   slave  (memory)   : the mirror image.
// mem_rd / mem_wr are level requests held until mem_done is seen.
interface mem_wb_stage_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_done;
  logic [15:0] mem_rd_data;

  modport master (
    output mem_addr, mem_wr_data, mem_rd, mem_wr,
    input  mem_done, mem_rd_data
  );

  modport slave (
    input  mem_addr, mem_wr_data, mem_rd, mem_wr,
    output mem_done, mem_rd_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register of the 5-stage core.
// Issues multi-cycle data-memory accesses, stalls upstream while an access is
// outstanding, aborts hung accesses after TIMEOUT busy cycles, and registers
// write-back data/control for the WB stage.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   *_in                instruction fields/control from the EX/MEM register
//   mem (master)        data-memory handshake (addr, wr_data, rd, wr, done, rd_data)
//   stall_out           combinational: 1 holds IF/ID/EX/EX_MEM registers
//   *_MEM_WB            registered write-back data/control
//   halt_MEM_WB         sticky: HALT retired or access aborted
//   err_out             sticky: memory timeout (or misaligned access)
//
// Parameters: TIMEOUT (>=2) busy cycles before abort; CNT_W must hold TIMEOUT.
// Build option: define MEM_ALIGN_CHECK_EN to reject odd memory addresses
// (no request, bubble, sticky err_out/halt_MEM_WB).
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] aluResult_in,
  input  logic [15:0] rdData2_in,
  input  logic [15:0] PC_2_in,
  input  logic        isNotHalt_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic [2:0]  writeRegSel_in,
  mem_wb_stage_if.master mem,
  output logic        stall_out,
  output logic [15:0] wbData_MEM_WB,
  output logic [2:0]  writeRegSel_MEM_WB,
  output logic        RegWrite_MEM_WB,
  output logic        valid_MEM_WB,
  output logic        halt_MEM_WB,
  output logic        err_out
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Request latches: the access is replayed from these while BUSY.
  logic [DATA_W-1:0]   addr_q, data_q;
  logic                rd_q, wr_q;
  logic                mtr_q, rw_q;
  logic [SEL_W-1:0]    sel_q;

  logic                stall_c;
  logic                issue, finish, abort;
  logic                is_mem, misalign;

  logic [DATA_W-1:0]   wb_data_d;
  logic [SEL_W-1:0]    wb_sel_d;
  logic                wb_rw_d, wb_valid_d;
  logic                halt_d, err_d;

  // PC+2 selection happens upstream; this block only picks ALU vs memory data.
  logic unused_pc2;
  assign unused_pc2 = ^PC_2_in;

  // HALT instructions are never treated as memory ops.
  assign is_mem = (MemRead_in | MemWrite_in) & isNotHalt_in;

  always_comb begin
    misalign = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = aluResult_in[0];
`endif
  end

  // Next-state, stall and MEM/WB capture values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    wb_data_d  = '0;
    wb_sel_d   = '0;
    wb_rw_d    = 1'b0;
    wb_valid_d = 1'b0;
    halt_d     = halt_MEM_WB;
    err_d      = err_out;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Once halted every input is a bubble.
        if (valid_in && !halt_MEM_WB) begin
          if (is_mem) begin
            if (misalign) begin
              err_d  = 1'b1;
              halt_d = 1'b1;
            end else begin
              stall_c = 1'b1;
              issue   = 1'b1;
              state_d = BUSY;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_rw_d    = RegWrite_in;
            wb_sel_d   = writeRegSel_in;
            wb_data_d  = MemToReg_in ? '0 : aluResult_in;
            if (!isNotHalt_in) halt_d = 1'b1;
          end
        end
      end

      BUSY: begin
        if (mem.mem_done) begin
          // Upstream is released this cycle; result retires next edge.
          finish     = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rw_d    = rw_q;
          wb_sel_d   = sel_q;
          wb_data_d  = mtr_q ? mem.mem_rd_data : addr_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          halt_d  = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted so all outputs read 0.
  assign stall_out = stall_c & rst;

  // State register, counter and request latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        addr_q <= aluResult_in;
        data_q <= rdData2_in;
        rd_q   <= MemRead_in;
        wr_q   <= MemWrite_in;
        mtr_q  <= MemToReg_in;
        rw_q   <= RegWrite_in;
        sel_q  <= writeRegSel_in;
      end else if (finish || abort) begin
        // Address/data hold their last values; only the requests drop.
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
    end
  end

  // MEM/WB pipeline register and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbData_MEM_WB      <= '0;
      writeRegSel_MEM_WB <= '0;
      RegWrite_MEM_WB    <= 1'b0;
      valid_MEM_WB       <= 1'b0;
      halt_MEM_WB        <= 1'b0;
      err_out            <= 1'b0;
    end else begin
      wbData_MEM_WB      <= wb_data_d;
      writeRegSel_MEM_WB <= wb_sel_d;
      RegWrite_MEM_WB    <= wb_rw_d;
      valid_MEM_WB       <= wb_valid_d;
      halt_MEM_WB        <= halt_d;
      err_out            <= err_d;
    end
  end

  assign mem.mem_addr    = addr_q;
  assign mem.mem_wr_data = data_q;
  assign mem.mem_rd      = rd_q;
  assign mem.mem_wr      = wr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (TIMEOUT=8). Stimulus pushes the expected
// write-back record with its expected capture cycle; a negedge monitor pops
// and compares whenever valid_MEM_WB is high.
module tb_mem_wb_stage;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, isNotHalt_in, MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in;
  logic [15:0] aluResult_in, rdData2_in, PC_2_in;
  logic [2:0]  writeRegSel_in;
  logic        stall_out, RegWrite_MEM_WB, valid_MEM_WB, halt_MEM_WB, err_out;
  logic [15:0] wbData_MEM_WB;
  logic [2:0]  writeRegSel_MEM_WB;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk                (clk),
    .rst                (rst_n),
    .valid_in           (valid_in),
    .aluResult_in       (aluResult_in),
    .rdData2_in         (rdData2_in),
    .PC_2_in            (PC_2_in),
    .isNotHalt_in       (isNotHalt_in),
    .MemToReg_in        (MemToReg_in),
    .MemRead_in         (MemRead_in),
    .MemWrite_in        (MemWrite_in),
    .RegWrite_in        (RegWrite_in),
    .writeRegSel_in     (writeRegSel_in),
    .mem                (bus),
    .stall_out          (stall_out),
    .wbData_MEM_WB      (wbData_MEM_WB),
    .writeRegSel_MEM_WB (writeRegSel_MEM_WB),
    .RegWrite_MEM_WB    (RegWrite_MEM_WB),
    .valid_MEM_WB       (valid_MEM_WB),
    .halt_MEM_WB        (halt_MEM_WB),
    .err_out            (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  sel;
    logic        rw;
    int          cyc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every retired instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid_MEM_WB) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got data=%h sel=%0d rw=%b at cyc %0d, required no retirement",
                 wbData_MEM_WB, writeRegSel_MEM_WB, RegWrite_MEM_WB, cyc);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        if (wbData_MEM_WB !== e.data || writeRegSel_MEM_WB !== e.sel ||
            RegWrite_MEM_WB !== e.rw || cyc != e.cyc) begin
          fails++;
          $display("FAIL wb_record: got data=%h sel=%0d rw=%b cyc=%0d, required data=%h sel=%0d rw=%b cyc=%0d",
                   wbData_MEM_WB, writeRegSel_MEM_WB, RegWrite_MEM_WB, cyc,
                   e.data, e.sel, e.rw, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic clear_inputs();
    valid_in = 1'b0; aluResult_in = '0; rdData2_in = '0; PC_2_in = '0;
    isNotHalt_in = 1'b1; MemToReg_in = 1'b0; MemRead_in = 1'b0;
    MemWrite_in = 1'b0; RegWrite_in = 1'b0; writeRegSel_in = '0;
    bus.mem_done = 1'b0; bus.mem_rd_data = '0;
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, stall_out, wbData_MEM_WB, writeRegSel_MEM_WB, RegWrite_MEM_WB,
            valid_MEM_WB, halt_MEM_WB, err_out, bus.mem_rd, bus.mem_wr, 5'd0};
  endfunction

  // Pulse reset between clock edges; outputs and requests must clear at once.
  task automatic do_reset(input string nm);
    #3 rst_n = 1'b0;
    #1 check({nm, "_outs_zero"}, all_outs(), 32'd0);
    check({nm, "_addr_zero"}, {bus.mem_addr, bus.mem_wr_data}, 32'd0);
    clear_inputs();
    sb.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Non-memory instruction, presented for one cycle; retires one edge later.
  task automatic alu(input logic [15:0] a, input logic mtr, rw, input logic [2:0] sel,
                     input logic nh, input logic [15:0] exp_data, input bit expect_out);
    wb_exp_t e;
    valid_in = 1'b1; aluResult_in = a; MemToReg_in = mtr; RegWrite_in = rw;
    writeRegSel_in = sel; isNotHalt_in = nh; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    PC_2_in = a + 16'd2;
    if (expect_out) begin
      e.data = exp_data; e.sel = sel; e.rw = rw; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    check("alu_no_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Memory op; mem_done on BUSY cycle done_at (0 = never). Counts stall and
  // request cycles and checks the driven address/data while requesting.
  task automatic do_mem(input string nm, input logic ld, input logic [15:0] a, d,
                        input logic mtr, rw, input logic [2:0] sel, input int done_at,
                        input logic [15:0] rdd, input logic [15:0] exp_data,
                        input int exp_stall, input int exp_req);
    int  n_stall = 0;
    int  n_req   = 0;
    bit  bus_ok  = 1'b1;
    wb_exp_t e;
    valid_in = 1'b1; aluResult_in = a; rdData2_in = d; MemRead_in = ld;
    MemWrite_in = !ld; MemToReg_in = mtr; RegWrite_in = rw; writeRegSel_in = sel;
    isNotHalt_in = 1'b1; bus.mem_rd_data = rdd;
    if (done_at > 0) begin
      e.data = exp_data; e.sel = sel; e.rw = rw; e.cyc = cyc + done_at + 1;
      sb.push_back(e);
    end
    for (int k = 0; k <= int'(TO); k++) begin
      bus.mem_done = (done_at > 0 && k == done_at);
      @(negedge clk);
      if (stall_out) n_stall++;
      if (bus.mem_rd || bus.mem_wr) begin
        n_req++;
        if (bus.mem_addr !== a || bus.mem_rd !== ld || bus.mem_wr !== !ld ||
            (!ld && bus.mem_wr_data !== d)) bus_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (done_at > 0 && k == done_at) break;
    end
    clear_inputs();
    check({nm, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    check({nm, "_req_cycles"}, 32'(n_req), 32'(exp_req));
    check({nm, "_bus_fields"}, {31'd0, bus_ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #12;
    check("reset_outs_zero", all_outs(), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU ops, then a bubble carrying junk fields.
    alu(16'h1234, 1'b0, 1'b1, 3'd3, 1'b1, 16'h1234, 1'b1);
    alu(16'h5555, 1'b1, 1'b1, 3'd6, 1'b1, 16'h0000, 1'b1);
    aluResult_in = 16'hFFFF; RegWrite_in = 1'b1; writeRegSel_in = 3'd7;
    @(posedge clk); #1;
    check("bubble_capture", {13'd0, valid_MEM_WB, RegWrite_MEM_WB, wbData_MEM_WB}, 32'd0);
    clear_inputs();

    // Load: done on 3rd BUSY cycle -> stall 3 cycles, mem_rd 3 cycles.
    do_mem("load", 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b1, 3'd5, 3, 16'hBEEF, 16'hBEEF, 3, 3);
    // Store: done on 1st BUSY cycle -> 2-cycle latency, wbData = address.
    do_mem("store", 1'b0, 16'h0040, 16'hA5A5, 1'b0, 1'b0, 3'd0, 1, 16'h0000, 16'h0040, 1, 1);
    @(negedge clk);
    check("store_addr_held", {bus.mem_addr, bus.mem_wr_data}, 32'h0040A5A5);

    // Reset in the middle of a load.
    @(posedge clk); #1;
    valid_in = 1'b1; MemRead_in = 1'b1; aluResult_in = 16'h0200; MemToReg_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_before_reset", {30'd0, bus.mem_rd, stall_out}, 32'd3);
    do_reset("midbusy");
    alu(16'h00C3, 1'b0, 1'b1, 3'd1, 1'b1, 16'h00C3, 1'b1);

    // HALT retires like an ALU op, then later ops are ignored.
    alu(16'h0BAD, 1'b0, 1'b1, 3'd2, 1'b0, 16'h0BAD, 1'b1);
    @(negedge clk);
    check("halt_set", {31'd0, halt_MEM_WB}, 32'd1);
    @(posedge clk); #1;
    do_mem("halted_load", 1'b1, 16'h0300, 16'h0000, 1'b1, 1'b1, 3'd4, 0, 16'h0000, 16'h0000, 0, 0);
    do_reset("after_halt");

    // Timeout: no mem_done -> 8 BUSY cycles of mem_rd, then abort.
    do_mem("timeout", 1'b1, 16'h0400, 16'h0000, 1'b1, 1'b1, 3'd4, 0, 16'h0000, 16'h0000, int'(TO), int'(TO));
    @(negedge clk);
    check("timeout_err_halt", {30'd0, err_out, halt_MEM_WB}, 32'd3);
    @(posedge clk); #1;
    do_mem("post_err_load", 1'b1, 16'h0500, 16'h0000, 1'b1, 1'b1, 3'd4, 0, 16'h0000, 16'h0000, 0, 0);
    alu(16'h7777, 1'b0, 1'b1, 3'd4, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    check("mem_done_idle_ignored", {31'd0, valid_MEM_WB}, 32'd0);
    do_reset("after_err");

`ifdef MEM_ALIGN_CHECK_EN
    do_mem("misaligned", 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b1, 3'd4, 0, 16'h0000, 16'h0000, 0, 0);
    @(negedge clk);
    check("misaligned_err", {30'd0, err_out, halt_MEM_WB}, 32'd3);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
